instruction_fetch_unit: RTL and testbench

//  Initiator side of the program-memory read port: drives the fetch address and collects the returned instruction words.

---
 rtl/instruction_fetch_unit_pkg.sv | 16 +
 rtl/instruction_fetch_unit_if.sv | 32 +++
 rtl/instruction_fetch_unit_fetch_buffer.sv | 51 +++++
 rtl/instruction_fetch_unit.sv | 86 ++++++++
 tb/tb_instruction_fetch_unit.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit: word geometry, the
// invalid-instruction encoding and FSM state codes.
package instruction_fetch_unit_pkg;
  localparam int INSTR_W     = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [INSTR_W-1:0] ZERO_INSTR = 32'h0;

  // FSM encodings kept as plain constants for legacy tools
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  // A byte address is a legal instruction target only on a word boundary
  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus bundle: program-memory read port, redirect request and
// the decode-side valid/ready handshake plus status.
interface instruction_fetch_unit_if #(
  parameter int PC_WIDTH  = 12,
  parameter int OPD_WIDTH = 32
);
  import instruction_fetch_unit_pkg::*;

  logic [PC_WIDTH-1:0]  pmem_addr;
  logic [INSTR_W-1:0]   pmem_data;
  logic [OPD_WIDTH-1:0] pmem_pc;
  logic                 redirect_en;
  logic [PC_WIDTH-1:0]  redirect_pc;
  logic [INSTR_W-1:0]   instr;
  logic [OPD_WIDTH-1:0] instr_pc;
  logic                 instr_valid;
  logic                 instr_ready;
  logic                 halted;
  logic                 misalign_err;

  // Fetch unit side
  modport master (
    output pmem_addr, instr, instr_pc, instr_valid, halted, misalign_err,
    input  pmem_data, pmem_pc, redirect_en, redirect_pc, instr_ready
  );

  // Memory / decode / control side
  modport slave (
    input  pmem_addr, instr, instr_pc, instr_valid, halted, misalign_err,
    output pmem_data, pmem_pc, redirect_en, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// Two-entry FIFO holding returned {instruction word, pc} pairs between the
// memory return and decode. Flush wins over push; push+pop at any count.
module instruction_fetch_unit_fetch_buffer #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);
  logic [1:0][W-1:0] mem;
  logic              wr_ptr, rd_ptr;
  logic [1:0]        cnt;
  logic              do_push, do_pop;

  assign do_pop  = pop & (cnt != 2'd0);
  // A full buffer still accepts a push when the head leaves the same cycle
  assign do_push = push & ((cnt != 2'd2) | do_pop);

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);
  assign count = cnt;

  // Storage, pointers and occupancy; flush discards everything queued
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues word fetches to program memory, absorbs
// the 1-cycle read latency in a 2-entry buffer, and presents tagged words
// to decode. Handles redirects, misaligned targets and the all-zero halt.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int          PC_WIDTH  = 12,
  parameter int          OPD_WIDTH = 32,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  instruction_fetch_unit_if.master bus
);
  localparam int BUF_W = INSTR_W + OPD_WIDTH;

  logic [0:0]          state;
  logic [PC_WIDTH-1:0] fetch_pc;
  logic                inflight;
  logic                misalign_q;

  logic                pop, push, flush, fire, credit_ok;
  logic                halt_now, redir_ok, redir_bad;
  logic                full, empty;
  logic [1:0]          count;
  logic [BUF_W-1:0]    head;
  logic [INSTR_W-1:0]  head_word;

  assign head_word = head[BUF_W-1 -: INSTR_W];

  assign pop       = ~empty & bus.instr_ready;
  assign redir_ok  = bus.redirect_en &  word_aligned(bus.redirect_pc[1:0]);
  assign redir_bad = bus.redirect_en & ~word_aligned(bus.redirect_pc[1:0]);
  // Delivering the all-zero word stops fetch; a same-cycle redirect overrides
  assign halt_now  = pop & (head_word == ZERO_INSTR) & ~bus.redirect_en;
  assign flush     = bus.redirect_en | halt_now;
  assign push      = inflight & ~flush;

  // Buffered + in-flight words may never exceed the two buffer slots. A slot
  // vacated by this cycle's pop is counted as free so that a held-high ready
  // sustains one word per cycle.
  assign credit_ok = pop ? ~(full & inflight)
                         : (({1'b0, count} + {2'b00, inflight}) < 3'd2);
  assign fire      = (state == ST_RUN) & ~flush & credit_ok;

  assign bus.pmem_addr    = fetch_pc;
  assign bus.instr_valid  = ~empty;
  assign bus.instr        = empty ? '0 : head_word;
  assign bus.instr_pc     = empty ? '0 : head[OPD_WIDTH-1:0];
  assign bus.halted       = (state == ST_HALT);
  assign bus.misalign_err = misalign_q;

  instruction_fetch_unit_fetch_buffer #(.W(BUF_W)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ({bus.pmem_data, bus.pmem_pc}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // FSM, fetch address, in-flight tracking and misalign pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_RUN;
      fetch_pc   <= PC_WIDTH'(RESET_PC);
      inflight   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      inflight   <= fire;
      misalign_q <= redir_bad;
      if (redir_ok) begin
        state    <= ST_RUN;
        fetch_pc <= bus.redirect_pc;
      end else if (redir_bad || halt_now) begin
        state    <= ST_HALT;
      end else if (fire) begin
        fetch_pc <= fetch_pc + PC_WIDTH'(INSTR_BYTES);
      end
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios followed by random
// ready/redirect traffic, all scored against a delivered-stream model.
module tb_instruction_fetch_unit;
  localparam int PCW = 12;
  localparam int OPW = 32;
  localparam logic [11:0] ZERO_ADDR = 12'd204;

  logic clk, rst;
  int   vectors = 0;
  int   miscompares = 0;

  instruction_fetch_unit_if #(.PC_WIDTH(PCW), .OPD_WIDTH(OPW)) bus ();

  instruction_fetch_unit #(.PC_WIDTH(PCW), .OPD_WIDTH(OPW), .RESET_PC(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory contents: every word nonzero except the one at ZERO_ADDR
  function automatic logic [31:0] memword(input logic [11:0] a);
    if (a == ZERO_ADDR) return 32'h0;
    return {a, 20'h00013};
  endfunction

  // Memory responder: samples the address each edge, answers next cycle
  always @(posedge clk) begin
    bus.pmem_data <= memword(bus.pmem_addr);
    bus.pmem_pc   <= {20'h0, bus.pmem_addr};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model state: next PC decode should see, halt status
  logic [11:0] exp_pc, prev_addr, a_m, rpc;
  bit          m_halted, m_stop, prev_bad, prev_hold, prev_halted;
  int          idle;
  logic        rdy, ren;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic observe();
    chk("misalign_err", 32'(bus.misalign_err), 32'(prev_bad));
    chk("halted", 32'(bus.halted), 32'(m_halted));
    if (m_stop) chk("valid_when_halted", 32'(bus.instr_valid), 32'd0);
    if (prev_hold) chk("valid_held", 32'(bus.instr_valid), 32'd1);
    if (bus.instr_valid) begin
      chk("instr_pc", bus.instr_pc, 32'(exp_pc));
      chk("instr", bus.instr, memword(exp_pc));
    end
    if (m_halted && prev_halted) chk("addr_frozen", 32'(bus.pmem_addr), 32'(prev_addr));
    if (bus.redirect_en || !bus.instr_ready || bus.instr_valid || m_halted) idle = 0;
    else idle++;
    chk("progress", 32'(idle > 3), 32'd0);
    // advance the model by what this cycle does
    prev_bad    = bus.redirect_en && (bus.redirect_pc[1:0] != 2'b00);
    prev_hold   = bus.instr_valid && !bus.instr_ready && !bus.redirect_en;
    prev_halted = m_halted;
    prev_addr   = bus.pmem_addr;
    if (bus.redirect_en) begin
      if (bus.redirect_pc[1:0] == 2'b00) begin
        m_halted = 1'b0; m_stop = 1'b0; exp_pc = bus.redirect_pc;
      end else begin
        m_halted = 1'b1; m_stop = 1'b1;
      end
    end else if (bus.instr_valid && bus.instr_ready) begin
      if (bus.instr == 32'h0) begin m_halted = 1'b1; m_stop = 1'b1; end
      exp_pc = exp_pc + 12'd4;
    end
  endtask

  task automatic cycle(input logic r, input logic e, input logic [11:0] p);
    @(negedge clk);
    bus.instr_ready = r; bus.redirect_en = e; bus.redirect_pc = p;
    #1 observe();
  endtask

  // One reset edge, check reset outputs, release; leaves us in cycle 0
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; bus.instr_ready = 1'b1; bus.redirect_en = 1'b0; bus.redirect_pc = '0;
    @(negedge clk); #1;
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_instr_pc", bus.instr_pc, 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_misalign", 32'(bus.misalign_err), 32'd0);
    chk("rst_addr", 32'(bus.pmem_addr), 32'd0);
    rst = 1'b1;
    exp_pc = '0; m_halted = 0; m_stop = 0; prev_bad = 0; prev_hold = 0;
    prev_halted = 0; prev_addr = '0; idle = 0;
    observe();
  endtask

  initial begin
    rst = 1'b0;
    bus.instr_ready = 1'b0; bus.redirect_en = 1'b0; bus.redirect_pc = '0;

    // 1: back-to-back fetch after reset
    do_reset();
    chk("t1_addr_c0", 32'(bus.pmem_addr), 32'd0);
    cycle(1, 0, 0);
    chk("t1_addr_c1", 32'(bus.pmem_addr), 32'd4);
    chk("t1_valid_c1", 32'(bus.instr_valid), 32'd0);
    cycle(1, 0, 0);
    chk("t1_addr_c2", 32'(bus.pmem_addr), 32'd8);
    chk("t1_valid_c2", 32'(bus.instr_valid), 32'd1);
    chk("t1_pc_c2", bus.instr_pc, 32'd0);
    cycle(1, 0, 0);
    chk("t1_pc_c3", bus.instr_pc, 32'd4);
    cycle(1, 0, 0);
    chk("t1_pc_c4", bus.instr_pc, 32'd8);

    // 2: decode stall for 5 cycles, then release
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0);
      chk("t2_addr_frozen", 32'(bus.pmem_addr), 32'd20);
      chk("t2_valid", 32'(bus.instr_valid), 32'd1);
      chk("t2_pc_stable", bus.instr_pc, 32'd12);
    end
    for (int i = 0; i < 6; i++) cycle(1, 0, 0);

    // 3: aligned redirect with a buffered word and one in flight
    cycle(0, 1, 12'd104);
    cycle(1, 0, 0);
    chk("t3_valid_r1", 32'(bus.instr_valid), 32'd0);
    chk("t3_addr_r1", 32'(bus.pmem_addr), 32'd104);
    cycle(1, 0, 0);
    chk("t3_valid_r2", 32'(bus.instr_valid), 32'd0);
    cycle(1, 0, 0);
    chk("t3_valid_r3", 32'(bus.instr_valid), 32'd1);
    chk("t3_pc_r3", bus.instr_pc, 32'd104);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0);

    // 4: misaligned redirect
    cycle(1, 1, 12'd106);
    a_m = bus.pmem_addr;
    cycle(1, 0, 0);
    chk("t4_misalign_pulse", 32'(bus.misalign_err), 32'd1);
    chk("t4_halted", 32'(bus.halted), 32'd1);
    chk("t4_valid", 32'(bus.instr_valid), 32'd0);
    chk("t4_addr_kept", 32'(bus.pmem_addr), 32'(a_m));
    cycle(1, 0, 0);
    chk("t4_misalign_end", 32'(bus.misalign_err), 32'd0);
    chk("t4_addr_kept2", 32'(bus.pmem_addr), 32'(a_m));

    // 5: all-zero word at 204 halts; redirect to 0 resumes
    cycle(1, 1, 12'd200);
    cycle(1, 0, 0);
    chk("t5_unhalt", 32'(bus.halted), 32'd0);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    chk("t5_pc200", bus.instr_pc, 32'd200);
    cycle(1, 0, 0);
    chk("t5_zero_valid", 32'(bus.instr_valid), 32'd1);
    chk("t5_zero_pc", bus.instr_pc, 32'd204);
    chk("t5_zero_word", bus.instr, 32'd0);
    cycle(1, 0, 0);
    chk("t5_halted", 32'(bus.halted), 32'd1);
    chk("t5_no_valid", 32'(bus.instr_valid), 32'd0);
    cycle(1, 0, 0);
    chk("t5_no_valid2", 32'(bus.instr_valid), 32'd0);
    cycle(1, 1, 12'd0);
    cycle(1, 0, 0);
    chk("t5_resume_halted", 32'(bus.halted), 32'd0);
    chk("t5_resume_addr", 32'(bus.pmem_addr), 32'd0);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    chk("t5_resume_pc", bus.instr_pc, 32'd0);

    // 6: address wrap, then reset mid-stream
    cycle(1, 1, 12'd4088);
    cycle(1, 0, 0);
    chk("t6_addr_4088", 32'(bus.pmem_addr), 32'd4088);
    cycle(1, 0, 0);
    chk("t6_addr_4092", 32'(bus.pmem_addr), 32'd4092);
    cycle(1, 0, 0);
    chk("t6_addr_wrap", 32'(bus.pmem_addr), 32'd0);
    chk("t6_pc_4088", bus.instr_pc, 32'd4088);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    chk("t6_pc_wrap", bus.instr_pc, 32'd0);
    do_reset();
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    chk("t6_restart_valid", 32'(bus.instr_valid), 32'd1);
    chk("t6_restart_pc", bus.instr_pc, 32'd0);

    // Random ready / redirect traffic
    for (int i = 0; i < 600; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      ren = ($urandom_range(0, 19) == 0);
      rpc = 12'($urandom_range(0, 1023) * 4);
      if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      cycle(rdy, ren, rpc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
